// File: rtl/stats_telemetry_tx.sv
// Telemetry framer: snapshots the pet stats into an 11-byte frame and streams it over valid/ready.
// Define TELEMETRY_CRC8_EN to replace the XOR checksum in byte 10 with CRC-8 (poly 0x07).
module stats_telemetry_tx #(
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter int unsigned PERIOD_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       second_tick,
  input  logic [4:0] hunger,
  input  logic [4:0] happiness,
  input  logic [4:0] health,
  input  logic [4:0] hygiene,
  input  logic [4:0] energy,
  input  logic [4:0] social,
  input  logic [7:0] status,
  input  logic       is_sleeping,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] frames_sent
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [7:0] LAST_TICK = 8'(PERIOD_TICKS - 1);
  localparam logic [3:0] LAST_IDX  = 4'd10;

  state_t     state, state_nxt;
  logic [7:0] tick_cnt;
  logic       pending;
  logic       overrun_q;
  logic [7:0] seq;
  logic [7:0] frames_cnt;
  logic [3:0] byte_idx;
  logic [7:0] csum;
  logic [7:0] csum_nxt;

  logic [4:0] snap_hunger, snap_happiness, snap_health;
  logic [4:0] snap_hygiene, snap_energy, snap_social;
  logic [7:0] snap_status;
  logic       snap_sleep;

  logic       trigger;
  logic       start;
  logic       hs;
  logic       last_hs;
  logic [7:0] cur_byte;

`ifdef TELEMETRY_CRC8_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  assign trigger = second_tick && (tick_cnt == LAST_TICK);
  assign start   = (state == IDLE) && (trigger || pending);
  assign hs      = (state == SEND) && tx_ready;
  assign last_hs = hs && (byte_idx == LAST_IDX);

  // Frame byte selection is purely from the snapshot so mid-frame input changes cannot leak in.
  always_comb begin
    cur_byte = '0;
    case (byte_idx)
      4'd0:    cur_byte = HEADER;
      4'd1:    cur_byte = seq;
      4'd2:    cur_byte = {3'b000, snap_hunger};
      4'd3:    cur_byte = {3'b000, snap_happiness};
      4'd4:    cur_byte = {3'b000, snap_health};
      4'd5:    cur_byte = {3'b000, snap_hygiene};
      4'd6:    cur_byte = {3'b000, snap_energy};
      4'd7:    cur_byte = {3'b000, snap_social};
      4'd8:    cur_byte = snap_status;
      4'd9:    cur_byte = {7'b0000000, snap_sleep};
      4'd10:   cur_byte = csum;
      default: cur_byte = '0;
    endcase
  end

  always_comb begin
`ifdef TELEMETRY_CRC8_EN
    csum_nxt = crc8_step(csum, cur_byte);
`else
    csum_nxt = csum ^ cur_byte;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = SEND;
      SEND:    if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_valid    = (state == SEND);
  assign busy        = (state == SEND);
  assign tx_data     = (state == SEND) ? cur_byte : '0;
  assign overrun     = overrun_q;
  assign frames_sent = frames_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      pending        <= 1'b0;
      overrun_q      <= 1'b0;
      seq            <= '0;
      frames_cnt     <= '0;
      byte_idx       <= '0;
      csum           <= '0;
      snap_hunger    <= '0;
      snap_happiness <= '0;
      snap_health    <= '0;
      snap_hygiene   <= '0;
      snap_energy    <= '0;
      snap_social    <= '0;
      snap_status    <= '0;
      snap_sleep     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (second_tick) begin
        tick_cnt <= trigger ? '0 : tick_cnt + 8'd1;
      end
      if (start) begin
        snap_hunger    <= hunger;
        snap_happiness <= happiness;
        snap_health    <= health;
        snap_hygiene   <= hygiene;
        snap_energy    <= energy;
        snap_social    <= social;
        snap_status    <= status;
        snap_sleep     <= is_sleeping;
        byte_idx       <= '0;
        csum           <= '0;
        // A fresh trigger coinciding with a pending start stays queued rather than vanishing.
        pending        <= pending && trigger;
      end else if (state == SEND) begin
        if (trigger) begin
          if (pending) overrun_q <= 1'b1;
          else         pending   <= 1'b1;
        end
        if (hs) begin
          if (byte_idx >= 4'd1 && byte_idx <= 4'd9) csum <= csum_nxt;
          if (last_hs) begin
            byte_idx   <= '0;
            seq        <= seq + 8'd1;
            frames_cnt <= frames_cnt + 8'd1;
          end else begin
            byte_idx <= byte_idx + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stats_telemetry_tx.sv
// Directed bench for stats_telemetry_tx: frame content, backpressure, snapshot, pending/overrun, reset, period/wrap.
module tb_stats_telemetry_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       second_tick, tick3;
  logic [4:0] hunger, happiness, health, hygiene, energy, social;
  logic [7:0] status;
  logic       is_sleeping;
  logic [7:0] tx_data, tx_data3;
  logic       tx_valid, tx_valid3;
  logic       tx_ready;
  logic       ready3;
  logic       busy, busy3, overrun, overrun3;
  logic [7:0] frames_sent, frames3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ef [11];

  always #5 clk = ~clk;

  stats_telemetry_tx #(.HEADER(8'hA5), .PERIOD_TICKS(1)) dut (
    .clk(clk), .rst_n(rst_n), .second_tick(second_tick),
    .hunger(hunger), .happiness(happiness), .health(health), .hygiene(hygiene),
    .energy(energy), .social(social), .status(status), .is_sleeping(is_sleeping),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun), .frames_sent(frames_sent)
  );

  stats_telemetry_tx #(.HEADER(8'hA5), .PERIOD_TICKS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .second_tick(tick3),
    .hunger(hunger), .happiness(happiness), .health(health), .hygiene(hygiene),
    .energy(energy), .social(social), .status(status), .is_sleeping(is_sleeping),
    .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(ready3),
    .busy(busy3), .overrun(overrun3), .frames_sent(frames3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8_ref(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  task automatic build(input logic [7:0] s);
    logic [7:0] c;
    ef[0] = 8'hA5; ef[1] = s;
    ef[2] = {3'b0, hunger};  ef[3] = {3'b0, happiness}; ef[4] = {3'b0, health};
    ef[5] = {3'b0, hygiene}; ef[6] = {3'b0, energy};    ef[7] = {3'b0, social};
    ef[8] = status;          ef[9] = {7'b0, is_sleeping};
    c = 8'h00;
    for (int i = 1; i <= 9; i++) begin
`ifdef TELEMETRY_CRC8_EN
      c = crc8_ref(c, ef[i]);
`else
      c = c ^ ef[i];
`endif
    end
    ef[10] = c;
  endtask

  // Receives one frame starting at the current sample point; mode 1 applies ready 1,0,0,1,...
  task automatic recv_frame(input string tag, input int mode, input int chg_at);
    int idx;
    int c;
    idx = 0;
    c = 0;
    while (idx < 11 && c < 100) begin
      tx_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (chg_at >= 0 && idx == chg_at) hunger = 5'd5;
      check({tag, "_valid"}, {31'b0, tx_valid}, 32'd1);
      check($sformatf("%s_b%0d", tag, idx), {24'b0, tx_data}, {24'b0, ef[idx]});
      step();
      if (tx_ready) idx++;
      c++;
    end
    check({tag, "_timeout"}, idx, 11);
  endtask

  task automatic fire();
    second_tick = 1'b1;
    step();
    second_tick = 1'b0;
  endtask

  initial begin
    int hs_cnt;
    int pos;
    logic [7:0] last_seq;

    rst_n = 1'b0; second_tick = 1'b0; tick3 = 1'b0; tx_ready = 1'b1; ready3 = 1'b1;
    hunger = 5'd10; happiness = 5'd31; health = 5'd16; hygiene = 5'd3; energy = 5'd0; social = 5'd1;
    status = 8'h81; is_sleeping = 1'b1;
    step(); step();
    check("rst_valid", {31'b0, tx_valid}, 0);
    check("rst_data", {24'b0, tx_data}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);
    check("rst_frames", {24'b0, frames_sent}, 0);
    rst_n = 1'b1;
    step();

    // Basic frame with hand-computed bytes
    ef = '{8'hA5, 8'h00, 8'h0A, 8'h1F, 8'h10, 8'h03, 8'h00, 8'h01, 8'h81, 8'h01, 8'h87};
`ifdef TELEMETRY_CRC8_EN
    build(8'h00);
`endif
    fire();
    recv_frame("basic", 0, -1);
    check("basic_idle", {31'b0, tx_valid}, 0);
    check("basic_frames", {24'b0, frames_sent}, 1);

    // Backpressure
    hunger = 5'd1; happiness = 5'd2; health = 5'd3; hygiene = 5'd4; energy = 5'd5; social = 5'd6;
    status = 8'h3C; is_sleeping = 1'b0;
    build(8'h01);
    fire();
    recv_frame("bp", 1, -1);
    tx_ready = 1'b1;
    check("bp_frames", {24'b0, frames_sent}, 2);

    // Snapshot isolation
    hunger = 5'd10; happiness = 5'd31; health = 5'd16; hygiene = 5'd3; energy = 5'd0; social = 5'd1;
    status = 8'h81; is_sleeping = 1'b1;
    build(8'h02);
    fire();
    recv_frame("snap", 0, 3);
    check("snap_hunger_b2", {24'b0, ef[2]}, 32'h0A);
    build(8'h03);
    fire();
    recv_frame("snap2", 0, -1);
    check("snap2_b2", {24'b0, ef[2]}, 32'h05);

    // Pending and overrun
    tx_ready = 1'b0;
    build(8'h04);
    fire();
    step();
    fire();
    check("pend_no_overrun", {31'b0, overrun}, 0);
    step();
    fire();
    check("pend_overrun", {31'b0, overrun}, 1);
    check("pend_hold_data", {24'b0, tx_data}, 32'hA5);
    recv_frame("pend_a", 0, -1);
    check("pend_gap_valid", {31'b0, tx_valid}, 0);
    step();
    build(8'h05);
    recv_frame("pend_b", 0, -1);
    check("pend_end_valid", {31'b0, tx_valid}, 0);
    check("pend_frames", {24'b0, frames_sent}, 6);
    check("pend_overrun_sticky", {31'b0, overrun}, 1);

    // Reset mid-frame
    build(8'h06);
    fire();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rstm_b%0d", i), {24'b0, tx_data}, {24'b0, ef[i]});
      step();
    end
    rst_n = 1'b0;
    step();
    check("rstm_valid", {31'b0, tx_valid}, 0);
    check("rstm_data", {24'b0, tx_data}, 0);
    check("rstm_overrun", {31'b0, overrun}, 0);
    check("rstm_frames", {24'b0, frames_sent}, 0);
    rst_n = 1'b1;
    step();
    build(8'h00);
    fire();
    recv_frame("rstm_new", 0, -1);
    check("rstm_new_frames", {24'b0, frames_sent}, 1);

    // Period 3 and wrap-around on the second instance
    hs_cnt = 0; pos = 0; last_seq = 8'h00;
    for (int k = 0; k < 768; k++) begin
      tick3 = 1'b1;
      for (int j = 0; j < 12; j++) begin
        if (tx_valid3) begin
          if (pos == 1) last_seq = tx_data3;
          hs_cnt++;
          pos = (pos == 10) ? 0 : pos + 1;
        end
        step();
        tick3 = 1'b0;
      end
      if (k == 1) check("per_frames_2ticks", {24'b0, frames3}, 0);
      if (k == 2) check("per_frames_3ticks", {24'b0, frames3}, 1);
    end
    check("wrap_bytes", hs_cnt, 256 * 11);
    check("wrap_frames", {24'b0, frames3}, 0);
    check("wrap_last_seq", {24'b0, last_seq}, 32'hFF);
    check("wrap_idle", {31'b0, tx_valid3}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
